// File: rtl/int16_to_fp32_seq.sv
// Sequential signed 16-bit integer to IEEE-754 single-precision converter.
// Normalises the magnitude one bit per cycle, so latency depends on the leading-zero count.
module int16_to_fp32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready and out_valid are pure decodes of state and never depend on the other side.

    logic [1:0]  r_state;
    logic        r_sign;
    logic [15:0] r_mag;
    logic [7:0]  r_exp;
    logic [31:0] r_out;

    logic [15:0] w_mag_abs;

    // Two's-complement negate; -32768 wraps to 0x8000, which is the correct unsigned magnitude.
    assign w_mag_abs = in_data[15] ? (~in_data + 16'd1) : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_mag   <= 16'd0;
            r_exp   <= 8'd0;
            r_out   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign <= in_data[15];
                        r_mag  <= w_mag_abs;
                        r_exp  <= 8'd142;
                        if (in_data == 16'd0) begin
                            r_out   <= 32'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (r_mag[15]) begin
                        // The leading one is implicit in the IEEE format and is dropped here.
                        r_out   <= {r_sign, r_exp, r_mag[14:0], 8'b0};
                        r_state <= S_DONE;
                    end else begin
                        r_mag <= {r_mag[14:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_data    = r_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_int16_to_fp32_seq.sv
// Self-checking bench for int16_to_fp32_seq: directed literal cases, a reset-abort case
// and a randomized run scored against a real-valued conversion model.
module tb_int16_to_fp32_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_ready = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];
    bit          busy = 0;
    bit          seen = 0;
    bit          prev_hold = 0;

    int16_to_fp32_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .o_dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: real-valued conversion through the double-precision encoding
    function automatic logic [31:0] model_fp(input logic [15:0] d);
        real         r;
        logic [63:0] b;
        int          e;
        if (d == 16'd0) return 32'd0;
        r = $itor($signed(d));
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic int model_lat(input logic [15:0] d);
        int a;
        int lz;
        if (d == 16'd0) return 1;
        a = $signed(d);
        if (a < 0) a = -a;
        lz = 0;
        while (a < 32768) begin
            a = a * 2;
            lz++;
        end
        return 2 + lz;
    endfunction

    // Scoreboard / compare process: sampled on the falling edge, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
            busy      = 0;
            seen      = 0;
            prev_hold = 0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !busy});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (!seen) check("latency", cyc - acc_q[0], lat_q[0]);
                    seen = 1;
                end
            end else if (prev_hold) begin
                check("out_valid_held", {31'd0, out_valid}, 32'd1);
            end
            prev_hold = out_valid && !out_ready;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                void'(lat_q.pop_front());
                busy = 0;
                seen = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_fp(in_data));
                acc_q.push_back(cyc);
                lat_q.push_back(model_lat(in_data));
                busy = 1;
            end
        end
    end

    // Randomized consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Driver tasks
    task automatic send(input logic [15:0] d);
        bit w;
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        do begin
            w = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!w && k < 100);
        if (!w) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic conv_check(input logic [15:0] d, input logic [31:0] exp, input int lat,
                              input int hold);
        int k;
        send(d);
        k = 1;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check($sformatf("dir_valid_%h", d), {31'd0, out_valid}, 32'd1);
        check($sformatf("dir_data_%h", d), out_data, exp);
        check($sformatf("dir_lat_%h", d), k, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((!in_ready || exp_q.size() != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    logic [15:0] corners[$];
    logic [15:0] v;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;

        // Pin the model with hand-computed values
        check("model_p1", model_fp(16'h0001), 32'h3F800000);
        check("model_min", model_fp(16'h8000), 32'hC7000000);
        check("model_max", model_fp(16'h7FFF), 32'h46FFFE00);
        check("model_m1", model_fp(16'hFFFF), 32'hBF800000);
        check("model_256", model_fp(16'h0100), 32'h43800000);
        check("model_lat_p1", model_lat(16'h0001), 17);
        check("model_lat_256", model_lat(16'h0100), 9);

        // In-valid during reset must not be accepted
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);

        out_ready = 1'b1;
        conv_check(16'h0001, 32'h3F800000, 17, 0);
        conv_check(16'h8000, 32'hC7000000, 2, 0);
        conv_check(16'h7FFF, 32'h46FFFE00, 3, 0);
        conv_check(16'hFFFF, 32'hBF800000, 17, 0);
        conv_check(16'h0100, 32'h43800000, 9, 0);
        out_ready = 1'b0;
        conv_check(16'h0000, 32'h00000000, 1, 5);

        // Reset in the third NORM cycle aborts the conversion
        wait_idle();
        out_ready = 1'b1;
        send(16'h0001);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        conv_check(16'h8000, 32'hC7000000, 2, 0);

        // Randomized traffic with corner operands mixed in
        for (int i = 0; i < 16; i++) begin
            v = 16'd1 << i;
            corners.push_back(v);
            corners.push_back(-v);
            corners.push_back(v - 16'd1);
        end
        corners.push_back(16'h8001);
        corners.push_back(16'h7FFF);
        rand_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_data = 16'($urandom);
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 3) == 0) v = corners[$urandom_range(0, corners.size() - 1)];
            else v = 16'($urandom_range(0, 65535));
            send(v);
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_idle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int16_to_fp32_seq.md
INT16_TO_FP32_SEQ -- requirements
Module: int16_to_fp32_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: in_valid  input  1  in_data holds a conversion request.
REQ-004 SHALL have port: in_ready  output  1  block can accept a request this cycle.
REQ-005 SHALL have port: in_data  input  16  two's-complement signed integer operand.
REQ-006 SHALL have port: out_valid  output  1  out_data holds a finished result.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 SHALL have port: out_data  output  32  IEEE-754 single-precision result: {sign, exp[7:0], frac[22:0]}.
REQ-009 SHALL have no parameters; all widths fixed as above.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, NORM, DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; in_ready is a pure decode of state.
REQ-012 SHALL accept a request on a cycle with in_valid=1 and in_ready=1.
REQ-013 SHALL ignore in_data whenever in_ready=0; in_data need not stay stable after acceptance.
REQ-014 On accept, SHALL register: sign=in_data[15]; mag=|in_data| as unsigned 16 bits (so -32768 gives mag=0x8000); exp=8'd142.
REQ-015 On accept with in_data=0, SHALL go IDLE->DONE with result 0x00000000 (positive zero only).
REQ-016 On accept with in_data!=0, SHALL go IDLE->NORM.
REQ-017 In NORM, if mag[15]=1: SHALL go to DONE and latch out_data={sign, exp, mag[14:0], 8'b0}.
REQ-018 In NORM, if mag[15]=0: SHALL shift mag left by 1, decrement exp by 1, and stay in NORM.
REQ-019 Latency SHALL be exactly 2+lz cycles from the accept edge to out_valid=1, where lz is the leading-zero count of mag (0..15). The zero operand SHALL have latency 1.
REQ-020 The conversion is exact: no rounding logic, no overflow, no subnormal output. The exponent range is 127..142.
REQ-021 SHALL drive out_valid=1 only in DONE.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 In DONE with out_ready=1, SHALL go DONE->IDLE; in_ready rises the following cycle. There is no same-cycle accept-and-release.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 Peak throughput SHALL be one result per 3+lz cycles; the block holds at most one operation in flight.

Reset
REQ-026 With rst=1 at a rising edge: state=IDLE, in_ready=1 after the edge, out_valid=0, out_data=0, mag=0, exp=0, sign=0.
REQ-027 Reset SHALL take priority over accept, the NORM step and the DONE release in the same cycle.
REQ-028 Reset during NORM or DONE SHALL discard the operation; no out_valid pulse follows.
REQ-029 in_valid asserted during reset SHALL NOT be accepted.

Verification
REQ-030 Accept in_data=0x0001 (+1) with out_ready=1 -> out_data=0x3F800000, out_valid at accept+17 cycles.
REQ-031 Accept 0x8000 (-32768) -> out_data=0xC7000000 at accept+2. Accept 0x7FFF -> 0x46FFFE00 at accept+3.
REQ-032 Accept 0xFFFF (-1) -> 0xBF800000. Accept 0x0100 (256) -> 0x43800000 at accept+9.
REQ-033 Accept 0x0000 -> 0x00000000 at accept+1. Hold out_ready=0 for 5 cycles -> out_valid and out_data stay stable and in_ready=0 throughout.
REQ-034 Assert rst in the 3rd NORM cycle of a +1 conversion -> no out_valid afterwards. in_ready=1 the cycle after reset. Next accept of 0x8000 -> 0xC7000000.
REQ-035 Run back-to-back random in_valid/out_ready over all 65536 inputs -> every result matches a real-valued int-to-float reference model, and no request is lost or duplicated.
